// File: rtl/alu_pkg.sv
// Shared definitions for alu_pipe: opcode encoding, FSM states and flag-bit positions.
package alu_pkg;

  // Opcode encoding; 12-15 are reserved and behave as undefined ops.
  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpCmp  = 4'd2;
  localparam logic [3:0] OpCmpr = 4'd3;
  localparam logic [3:0] OpAnd  = 4'd4;
  localparam logic [3:0] OpOr   = 4'd5;
  localparam logic [3:0] OpXor  = 4'd6;
  localparam logic [3:0] OpNot  = 4'd7;
  localparam logic [3:0] OpLsh  = 4'd8;
  localparam logic [3:0] OpRsh  = 4'd9;
  localparam logic [3:0] OpArsh = 4'd10;
  localparam logic [3:0] OpMul  = 4'd11;

  typedef enum logic [0:0] {
    StIdle,
    StMulBusy
  } state_e;

  // Bit positions inside the packed 4-bit flag vector.
  localparam int unsigned FlagIdx = 0;
  localparam int unsigned LowIdx  = 1;
  localparam int unsigned NegIdx  = 2;
  localparam int unsigned ZeroIdx = 3;

endpackage

// File: rtl/alu_pipe_comb.sv
// Combinational result/flag evaluator for every single-cycle alu_pipe op.
// MUL and reserved opcodes yield c=0 with all flags clear.
module alu_pipe_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic [WIDTH-1:0] c,
  output logic [3:0]       flags
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] neg_b;
  logic [SHW-1:0]   sh;
  logic             sh_big;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign neg_b  = -b;
  assign sh     = a[SHW-1:0];
  // WIDTH is a power of two, so any set bit above the count field means a >= WIDTH.
  assign sh_big = |a[WIDTH-1:SHW];

  // Decode the opcode into a result and its flags; unlisted flags stay 0.
  always_comb begin
    c     = '0;
    flags = '0;
    case (opcode)
      OpAdd: begin
        c                = sum[WIDTH-1:0];
        flags[FlagIdx]   = (a[WIDTH-1] == b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
        flags[LowIdx]    = sum[WIDTH];
        flags[NegIdx]    = c[WIDTH-1];
        flags[ZeroIdx]   = (c == '0);
      end
      OpSub: begin
        c                = diff[WIDTH-1:0];
        // Overflow judged as the addition a + (-b).
        flags[FlagIdx]   = (a[WIDTH-1] == neg_b[WIDTH-1]) && (c[WIDTH-1] != a[WIDTH-1]);
        flags[LowIdx]    = diff[WIDTH];
        flags[NegIdx]    = c[WIDTH-1];
        flags[ZeroIdx]   = (a == b);
      end
      OpCmp: begin
        flags[LowIdx]    = a < b;
        flags[NegIdx]    = $signed(a) < $signed(b);
        flags[ZeroIdx]   = (a == b);
      end
      OpCmpr: begin
        flags[LowIdx]    = b < a;
        flags[NegIdx]    = $signed(b) < $signed(a);
        flags[ZeroIdx]   = (a == b);
      end
      OpAnd, OpOr, OpXor, OpNot: begin
        unique case (opcode)
          OpAnd:   c = a & b;
          OpOr:    c = a | b;
          OpXor:   c = a ^ b;
          default: c = ~a;
        endcase
        flags[NegIdx]    = c[WIDTH-1];
        flags[ZeroIdx]   = (c == '0);
      end
      OpLsh: begin
        c                = sh_big ? '0 : (b << sh);
        flags[ZeroIdx]   = (c == '0);
      end
      OpRsh: begin
        c                = sh_big ? '0 : (b >> sh);
        flags[ZeroIdx]   = (c == '0);
      end
      OpArsh: begin
        c                = sh_big ? {WIDTH{b[WIDTH-1]}} : WIDTH'($signed(b) >>> sh);
        flags[ZeroIdx]   = (c == '0);
      end
      default: begin
        c     = '0;
        flags = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides.
// Optional multi-cycle shift-add MUL is compiled in when ALU_PIPE_MUL_EN is defined;
// otherwise MUL behaves as an undefined opcode (c=0, flags 0, one cycle).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             flag,
  output logic             low,
  output logic             negative,
  output logic             zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] alu_c;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] c_q;
  logic [3:0]       flags_q;
  logic             out_valid_q;
  logic             accept;

  alu_pipe_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .c      (alu_c),
    .flags  (alu_flags)
  );

`ifdef ALU_PIPE_MUL_EN
  localparam logic [SHW-1:0] LastStep = SHW'(WIDTH - 1);

  state_e             state_q;
  logic [SHW-1:0]     count_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [3:0]         mul_flags;

  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Flags for the product as it stands after the current shift-add step.
  always_comb begin
    mul_flags          = '0;
    mul_flags[FlagIdx] = |acc_step[2*WIDTH-1:WIDTH];
    mul_flags[NegIdx]  = acc_step[WIDTH-1];
    mul_flags[ZeroIdx] = (acc_step[WIDTH-1:0] == '0);
  end
`else
  assign in_ready = !out_valid_q || out_ready;
`endif

  assign accept = in_valid && in_ready;

  // Control FSM, multiplier datapath and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= StIdle;
      count_q     <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
`ifdef ALU_PIPE_MUL_EN
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (opcode == OpMul) begin
              state_q  <= StMulBusy;
              count_q  <= '0;
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
            end else begin
              c_q         <= alu_c;
              flags_q     <= alu_flags;
              out_valid_q <= 1'b1;
            end
          end
        end
        StMulBusy: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + SHW'(1);
          if (count_q == LastStep) begin
            c_q         <= acc_step[WIDTH-1:0];
            flags_q     <= mul_flags;
            out_valid_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
`else
      if (accept) begin
        c_q         <= alu_c;
        flags_q     <= alu_flags;
        out_valid_q <= 1'b1;
      end
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign flag      = flags_q[FlagIdx];
  assign low       = flags_q[LowIdx];
  assign negative  = flags_q[NegIdx];
  assign zero      = flags_q[ZeroIdx];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, table-driven bench for alu_pipe at WIDTH=16, plus backpressure and
// mid-MUL reset sequences. MUL expectations follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    opcode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  c;
  logic          flag;
  logic          low;
  logic          negative;
  logic          zero;

  int checks   = 0;
  int failures = 0;

  alu_pipe #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flag      (flag),
    .low       (low),
    .negative  (negative),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Expected flags packed as {zero, negative, low, flag}.
  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ec;
    logic [3:0]   ef;
    int           elat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] op, logic [W-1:0] va, logic [W-1:0] vb,
                              logic [W-1:0] ec, logic [3:0] ef, int elat);
    vec_t v;
    v.op = op; v.va = va; v.vb = vb; v.ec = ec; v.ef = ef; v.elat = elat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] cur_flags();
    return {zero, negative, low, flag};
  endfunction

  // Present one op, wait for acceptance, then count edges until out_valid rises.
  // lat=0 means the result is visible right after the accepting edge.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       output int lat, output int busy_bad);
    int n;
    n        = 0;
    lat      = 0;
    busy_bad = 0;
    @(negedge clk);
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (n >= 50) begin
      lat = 999;
    end else begin
      while (!out_valid && lat < 100) begin
        if (in_ready) busy_bad++;
        @(posedge clk);
        #1;
        lat++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int busy_bad;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    opcode    = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_c", {16'b0, c}, 32'd0);
    chk("rst_flags", {28'b0, cur_flags()}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;

    vecs.push_back(mk(OpAdd,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 0));
    vecs.push_back(mk(OpAdd,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 0));
    vecs.push_back(mk(OpAdd,  16'h1234, 16'h4321, 16'h5555, 4'b0000, 0));
    vecs.push_back(mk(OpSub,  16'h0005, 16'h0005, 16'h0000, 4'b1000, 0));
    vecs.push_back(mk(OpSub,  16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 0));
    vecs.push_back(mk(OpSub,  16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 0));
    vecs.push_back(mk(OpCmp,  16'hFFFF, 16'h0001, 16'h0000, 4'b0100, 0));
    vecs.push_back(mk(OpCmp,  16'h0001, 16'hFFFF, 16'h0000, 4'b0010, 0));
    vecs.push_back(mk(OpCmpr, 16'hFFFF, 16'h0001, 16'h0000, 4'b0010, 0));
    vecs.push_back(mk(OpCmp,  16'h1234, 16'h1234, 16'h0000, 4'b1000, 0));
    vecs.push_back(mk(OpAnd,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 0));
    vecs.push_back(mk(OpOr,   16'h8000, 16'h0001, 16'h8001, 4'b0100, 0));
    vecs.push_back(mk(OpXor,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 0));
    vecs.push_back(mk(OpNot,  16'h0000, 16'h1234, 16'hFFFF, 4'b0100, 0));
    vecs.push_back(mk(OpLsh,  16'd16,   16'h0001, 16'h0000, 4'b1000, 0));
    vecs.push_back(mk(OpLsh,  16'd15,   16'h0001, 16'h8000, 4'b0000, 0));
    vecs.push_back(mk(OpRsh,  16'd4,    16'h00F0, 16'h000F, 4'b0000, 0));
    vecs.push_back(mk(OpRsh,  16'h0100, 16'hFFFF, 16'h0000, 4'b1000, 0));
    vecs.push_back(mk(OpArsh, 16'd20,   16'h8000, 16'hFFFF, 4'b0000, 0));
    vecs.push_back(mk(OpArsh, 16'd4,    16'h8000, 16'hF800, 4'b0000, 0));
    vecs.push_back(mk(OpArsh, 16'd15,   16'h4000, 16'h0000, 4'b1000, 0));
    vecs.push_back(mk(4'd12,  16'h0001, 16'h0001, 16'h0000, 4'b0000, 0));
    vecs.push_back(mk(4'd15,  16'hFFFF, 16'hFFFF, 16'h0000, 4'b0000, 0));
`ifdef ALU_PIPE_MUL_EN
    vecs.push_back(mk(OpMul,  16'h0003, 16'hFFFF, 16'hFFFD, 4'b0101, W));
    vecs.push_back(mk(OpMul,  16'h0010, 16'h0020, 16'h0200, 4'b0000, W));
    vecs.push_back(mk(OpMul,  16'h0100, 16'h0100, 16'h0000, 4'b1001, W));
`else
    vecs.push_back(mk(OpMul,  16'h0003, 16'hFFFF, 16'h0000, 4'b0000, 0));
`endif

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].va, vecs[i].vb, lat, busy_bad);
      chk($sformatf("vec%0d_op%0d_lat", i, vecs[i].op), lat, vecs[i].elat);
      chk($sformatf("vec%0d_op%0d_c", i, vecs[i].op), {16'b0, c}, {16'b0, vecs[i].ec});
      chk($sformatf("vec%0d_op%0d_flags", i, vecs[i].op), {28'b0, cur_flags()},
          {28'b0, vecs[i].ef});
      if (vecs[i].elat > 0) chk($sformatf("vec%0d_busy_in_ready", i), busy_bad, 0);
    end
    @(posedge clk);
    #1;
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure: ADD result held, queued XOR replaces it on the consuming edge.
    out_ready = 1'b0;
    do_op(OpAdd, 16'h0001, 16'h0002, lat, busy_bad);
    chk("bp_add_lat", lat, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    opcode   = OpXor;
    a        = 16'h00FF;
    b        = 16'h0F0F;
    in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    chk("bp_c_held", {16'b0, c}, 32'h0003);
    chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp_c_still_held", {16'b0, c}, 32'h0003);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_b2b_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_b2b_c", {16'b0, c}, 32'h0FF0);
    chk("bp_b2b_flags", {28'b0, cur_flags()}, 32'd0);
    @(posedge clk);
    #1;
    chk("bp_consumed", {31'b0, out_valid}, 32'd0);

    // Reset pulsed while a MUL is in flight.
    @(negedge clk);
    opcode   = OpMul;
    a        = 16'h0003;
    b        = 16'h0005;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mrst_c", {16'b0, c}, 32'd0);
    chk("mrst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_post_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (W + 2) @(posedge clk);
    #1;
    chk("mrst_no_stale_result", {31'b0, out_valid}, 32'd0);
    do_op(OpAdd, 16'h0002, 16'h0003, lat, busy_bad);
    chk("mrst_add_lat", lat, 0);
    chk("mrst_add_c", {16'b0, c}, 32'h0005);
    chk("mrst_add_flags", {28'b0, cur_flags()}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's combinational 16-bit ALU.
- Width is generic. Operands are accepted through a valid/ready handshake and results leave through a valid/ready handshake.
- Results and flags are registered. MUL is multi-cycle shift-add, compiled in via macro.
- Sits between the register-file read stage and writeback in the next CPU datapath.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4, power of two).
- SHW, $clog2(WIDTH), width of shift-count field (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept an operation this cycle
- a  in  WIDTH  operand A (shift count for shifts)
- b  in  WIDTH  operand B (shifted value for shifts)
- opcode  in  4  operation select (package encoding)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- c  out  WIDTH  result
- flag  out  1  signed overflow
- low  out  1  unsigned less-than / carry per op
- negative  out  1  sign / signed less-than per op
- zero  out  1  zero / equality per op

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, c=0, all flags=0, internal multiplier regs=0. This holds regardless of an in-flight MUL; no partial result survives reset.
- Transfer rules:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on a rising edge with in_valid && in_ready.
  - A result is consumed on out_valid && out_ready.
- States:
  - IDLE: on accept of a non-MUL op, register result+flags and set out_valid=1 on the same edge (latency 1 cycle, throughput 1/cycle under out_ready=1). On accept of MUL, go to MUL_BUSY with count=0.
  - MUL_BUSY: one shift-add step per cycle for WIDTH cycles. On the final step, write c and flags, set out_valid=1, and return to IDLE. MUL latency is WIDTH cycles. in_ready=0 throughout.
- out_valid clears on consume unless a new op is accepted on the same edge; in that case the new result replaces the old one (back-to-back, no bubble).
- With out_ready=0 and out_valid=1: c/flags held stable, in_ready=0.
- Arithmetic is modulo 2^WIDTH. Default for every op: flags not listed below are 0.
  - ADD: c=a+b; flag=signed overflow; low=carry-out; negative=c[MSB]; zero=(c==0).
  - SUB: c=a-b; flag=signed overflow of a+(-b); low=borrow (a<b unsigned); negative=c[MSB]; zero=(a==b).
  - CMP: c=0; low=a<b unsigned; negative=a<b signed; zero=(a==b).
  - CMPR: as CMP with a and b swapped.
  - AND/OR/XOR: c=a op b; negative=c[MSB]; zero=(c==0).
  - NOT: c=~a; negative=c[MSB]; zero=(c==0).
  - LSH/RSH: c=b<< a or b>> a, using the full a. If a>=WIDTH, c=0. zero=(c==0).
  - ARSH: c=signed b>>>a. If a>=WIDTH, c=replicated b[MSB]. zero=(c==0).
  - MUL: c=low WIDTH bits of a*b (unsigned; identical for two's complement); flag=1 if upper WIDTH bits are nonzero; negative=c[MSB]; zero=(c==0).
  - Undefined opcode: accepted; c=0; all flags 0; 1-cycle latency.
- in_valid while in_ready=0 is ignored. The source must hold its operands.

Optional Feature:
- Macro: ALU_PIPE_MUL_EN.
- Defined: MUL opcode and the MUL_BUSY state are implemented as above.
- Undefined: the multiplier logic and state are absent. MUL behaves as an undefined opcode (c=0, flags 0, 1-cycle latency). state never leaves IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams: ADD=0, SUB=1, CMP=2, CMPR=3, AND=4, OR=5, XOR=6, NOT=7, LSH=8, RSH=9, ARSH=10, MUL=11; 12-15 reserved.
  - state encoding: IDLE, MUL_BUSY.
  - flag-bit index constants.
- One sub-module: alu_pipe_comb, the parametrised combinational op/flag evaluator for all single-cycle ops. The top holds the FSM, multiplier and output register.

Test Plan (WIDTH=16):
- ADD a=0x7FFF b=0x0001 -> one cycle later out_valid=1, c=0x8000, flag=1, negative=1, zero=0, low=0.
- SUB a=0x0005 b=0x0005 -> c=0x0000, zero=1. CMP a=0xFFFF b=0x0001 -> low=0, negative=1, c=0.
- ARSH a=20 b=0x8000 -> c=0xFFFF. LSH a=16 b=0x0001 -> c=0x0000, zero=1. RSH a=4 b=0x00F0 -> c=0x000F.
- MUL (macro on) a=0x0003 b=0xFFFF -> in_ready=0 for 16 cycles, then c=0xFFFD, flag=1. With macro off -> c=0, 1 cycle.
- Backpressure: out_ready=0 after ADD -> c held, in_ready=0. Raise out_ready with a queued XOR -> consume and new result on the same edge, no bubble.
- rst_n pulsed low mid-MUL (cycle 7) -> out_valid=0, c=0, in_ready=1 after release. A fresh ADD then completes normally.
